// File: rtl/queue_pkg.sv
// Shared constants and types for the queue scheduler.
// Feature macro QUEUE_SCHED_RR_EN selects round-robin producer arbitration.
package queue_pkg;

    localparam int DATA_WIDTH  = 6;
    localparam int QUEUE_DEPTH = 4;
    localparam int SEL_W       = 2;
    localparam int CNT_W       = 3;

    localparam logic [1:0] Q_FLAG_IDLE    = 2'b00;
    localparam logic [1:0] Q_FLAG_PUSH    = 2'b01;
    localparam logic [1:0] Q_FLAG_POP     = 2'b10;
    localparam logic [1:0] Q_FLAG_PUSHPOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

endpackage

// File: rtl/queue_sched_arb.sv
// One-hot push-producer arbiter: fixed priority (index 0 first) by default,
// round-robin with a rotating pointer when QUEUE_SCHED_RR_EN is defined.
module queue_sched_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
`ifdef QUEUE_SCHED_RR_EN
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          adv_i,
`endif
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

`ifdef QUEUE_SCHED_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
`endif
    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
`ifdef QUEUE_SCHED_RR_EN
            j = (int'(ptr_q) + k) % N;
`else
            j = k;
`endif
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

`ifdef QUEUE_SCHED_RR_EN
    // Pointer moves past the winner on every push grant, zero drops included.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/queue_sched.sv
// Controller/arbiter for the 4-entry random-access pop queue.
// Optional QUEUE_SCHED_RR_EN: round-robin producer arbitration.
module queue_sched
    import queue_pkg::*;
#(
    parameter int N_PROD      = 4,
    parameter int DATA_WIDTH  = queue_pkg::DATA_WIDTH,
    parameter int QUEUE_DEPTH = queue_pkg::QUEUE_DEPTH,
    parameter int SEL_W       = queue_pkg::SEL_W,
    parameter int CNT_W       = queue_pkg::CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PROD-1:0]            push_req,
    input  logic [N_PROD*DATA_WIDTH-1:0] push_data,
    output logic [N_PROD-1:0]            push_gnt,
    input  logic                         pop_req,
    input  logic [SEL_W-1:0]             pop_sel,
    output logic                         pop_gnt,
    output logic                         pop_valid,
    output logic                         pop_err,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic [1:0]                   q_flag,
    output logic [SEL_W-1:0]             q_sel,
    output logic [DATA_WIDTH-1:0]        q_data_in,
    input  logic [DATA_WIDTH-1:0]        q_data_out,
    output logic [CNT_W-1:0]             count,
    output logic                         zero_drop,
    output logic                         busy
);

    localparam int IW = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    state_e                  state_q, state_d;
    op_e                     last_op_q, last_op_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [1:0]              flag_q, flag_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [N_PROD-1:0]       pgnt_q, pgnt_d;
    logic                    popgnt_q, popgnt_d;
    logic                    zdrop_q, zdrop_d;
    logic                    inc_q, inc_d;
    logic                    dec_q, dec_d;
    logic                    rpop_q, rpop_d;
    logic                    rerr_q, rerr_d;
    logic                    pvalid_q, pvalid_d;
    logic                    perr_q, perr_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;

    logic [N_PROD-1:0]       arb_gnt;
    logic [IW-1:0]           arb_idx;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    push_ok, pop_ok, pick_pop, pick_push;

    queue_sched_arb #(
        .N  (N_PROD),
        .IW (IW)
    ) u_arb (
`ifdef QUEUE_SCHED_RR_EN
        .clk_i  (clk),
        .rst_ni (rst_n),
        .adv_i  (pick_push && (state_q == ST_IDLE)),
`endif
        .req_i  (push_req),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    assign win_data  = push_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    assign push_ok   = (|push_req) && (count_q < CNT_W'(QUEUE_DEPTH));
    assign pop_ok    = (count_q != '0) && (CNT_W'(pop_sel) < count_q);
    // On contention the op not taken last time wins.
    assign pick_pop  = pop_req && (!push_ok || (last_op_q == OP_PUSH));
    assign pick_push = push_ok && !pick_pop;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        last_op_d = last_op_q;
        flag_d    = Q_FLAG_IDLE;
        sel_d     = '0;
        din_d     = '0;
        pgnt_d    = '0;
        popgnt_d  = 1'b0;
        zdrop_d   = 1'b0;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        rpop_d    = rpop_q;
        rerr_d    = rerr_q;
        pvalid_d  = 1'b0;
        perr_d    = 1'b0;
        pdata_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_pop) begin
                    state_d   = ST_ISSUE;
                    popgnt_d  = 1'b1;
                    last_op_d = OP_POP;
                    rpop_d    = 1'b1;
                    if (pop_ok) begin
                        flag_d = Q_FLAG_POP;
                        sel_d  = pop_sel;
                        dec_d  = 1'b1;
                    end else begin
                        rerr_d = 1'b1;
                    end
                end else if (pick_push) begin
                    state_d   = ST_ISSUE;
                    pgnt_d    = arb_gnt;
                    last_op_d = OP_PUSH;
                    if (win_data != '0) begin
                        flag_d = Q_FLAG_PUSH;
                        din_d  = win_data;
                        inc_d  = 1'b1;
                    end else begin
                        zdrop_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                if (inc_q) begin
                    count_d = count_q + CNT_W'(1);
                end else if (dec_q) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rpop_d  = 1'b0;
                rerr_d  = 1'b0;
                if (rpop_q) begin
                    pvalid_d = 1'b1;
                    perr_d   = rerr_q;
                    pdata_d  = rerr_q ? '0 : q_data_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_op_q <= OP_PUSH;
            count_q   <= '0;
            flag_q    <= Q_FLAG_IDLE;
            sel_q     <= '0;
            din_q     <= '0;
            pgnt_q    <= '0;
            popgnt_q  <= 1'b0;
            zdrop_q   <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            rpop_q    <= 1'b0;
            rerr_q    <= 1'b0;
            pvalid_q  <= 1'b0;
            perr_q    <= 1'b0;
            pdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_op_q <= last_op_d;
            count_q   <= count_d;
            flag_q    <= flag_d;
            sel_q     <= sel_d;
            din_q     <= din_d;
            pgnt_q    <= pgnt_d;
            popgnt_q  <= popgnt_d;
            zdrop_q   <= zdrop_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            rpop_q    <= rpop_d;
            rerr_q    <= rerr_d;
            pvalid_q  <= pvalid_d;
            perr_q    <= perr_d;
            pdata_q   <= pdata_d;
        end
    end

    assign push_gnt  = pgnt_q;
    assign pop_gnt   = popgnt_q;
    assign pop_valid = pvalid_q;
    assign pop_err   = perr_q;
    assign pop_data  = pdata_q;
    assign q_flag    = flag_q;
    assign q_sel     = sel_q;
    assign q_data_in = din_q;
    assign count     = count_q;
    assign zero_drop = zdrop_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_queue_sched.sv
// Self-checking bench for queue_sched with a behavioural queue_data stand-in
// and a scoreboard of expected pop responses.
module tb_queue_sched;

    localparam int NP = 4;
    localparam int DW = 6;

    logic            clk;
    logic            rst_n;
    logic [NP-1:0]   push_req;
    logic [NP*DW-1:0] push_data;
    logic [NP-1:0]   push_gnt;
    logic            pop_req;
    logic [1:0]      pop_sel;
    logic            pop_gnt;
    logic            pop_valid;
    logic            pop_err;
    logic [DW-1:0]   pop_data;
    logic [1:0]      q_flag;
    logic [1:0]      q_sel;
    logic [DW-1:0]   q_data_in;
    logic [DW-1:0]   q_data_out;
    logic [2:0]      count;
    logic            zero_drop;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_q[$];
    logic [DW:0]   sb[$];
    logic [DW:0]   mon_e;

    logic [DW-1:0] qm[4];
    int            qn;
    logic [DW-1:0] qdout;

    queue_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_req   (push_req),
        .push_data  (push_data),
        .push_gnt   (push_gnt),
        .pop_req    (pop_req),
        .pop_sel    (pop_sel),
        .pop_gnt    (pop_gnt),
        .pop_valid  (pop_valid),
        .pop_err    (pop_err),
        .pop_data   (pop_data),
        .q_flag     (q_flag),
        .q_sel      (q_sel),
        .q_data_in  (q_data_in),
        .q_data_out (q_data_out),
        .count      (count),
        .zero_drop  (zero_drop),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the random-access pop queue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qn = 0;
            qdout <= '0;
            for (int i = 0; i < 4; i++) qm[i] = '0;
        end else if (q_flag == 2'b01) begin
            if (qn < 4) begin
                qm[qn] = q_data_in;
                qn++;
            end
        end else if (q_flag == 2'b10) begin
            qdout <= qm[q_sel];
            for (int i = int'(q_sel); i < 3; i++) qm[i] = qm[i+1];
            qm[3] = '0;
            if (qn > 0) qn--;
        end
    end
    assign q_data_out = qdout;

    always @(negedge clk) begin
        if (rst_n && pop_valid) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL pop_unexpected got=%b/%h want no response",
                         pop_err, pop_data);
                errors++;
            end else begin
                mon_e = sb.pop_front();
                if ({pop_err, pop_data} !== mon_e) begin
                    $display("FAIL pop_resp got err=%b data=%h want err=%b data=%h",
                             pop_err, pop_data, mon_e[DW], mon_e[DW-1:0]);
                    errors++;
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        push_req = '0;
        push_data = '0;
        pop_req = 1'b0;
        pop_sel = '0;
        ref_q.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            $display("FAIL idle_timeout busy=%b want 0", busy);
            errors++;
        end
    endtask

    task automatic wait_push_gnt(input int p);
        int n = 0;
        while (!push_gnt[p] && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!push_gnt[p]) begin
            $display("FAIL push_gnt_timeout p=%0d got=%b", p, push_gnt);
            errors++;
        end
    endtask

    task automatic do_push(input int p, input logic [DW-1:0] d);
        push_data[p*DW +: DW] = d;
        push_req[p] = 1'b1;
        wait_push_gnt(p);
        push_req[p] = 1'b0;
        if (d != '0 && ref_q.size() < 4) ref_q.push_back(d);
        wait_idle();
    endtask

    task automatic do_pop(input int sel);
        logic err;
        int   n;
        err = (sel >= ref_q.size());
        if (err) begin
            sb.push_back({1'b1, {DW{1'b0}}});
        end else begin
            sb.push_back({1'b0, ref_q[sel]});
            ref_q.delete(sel);
        end
        pop_sel = 2'(sel);
        pop_req = 1'b1;
        n = 0;
        while (!pop_gnt && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!pop_gnt) begin
            $display("FAIL pop_gnt_timeout got=%b want 1", pop_gnt);
            errors++;
        end
        pop_req = 1'b0;
        checks++;
        if (q_flag !== (err ? 2'b00 : 2'b10)) begin
            $display("FAIL pop_flag got=%b want %b", q_flag, err ? 2'b00 : 2'b10);
            errors++;
        end
        n = 0;
        while (!pop_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 2) begin
            $display("FAIL pop_latency got=%0d want 2", n);
            errors++;
        end
        wait_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push_req = '0;
        push_data = '0;
        pop_req = 1'b0;
        pop_sel = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({push_gnt, pop_gnt, pop_valid, pop_err, pop_data, q_flag, q_sel,
             q_data_in, count, zero_drop, busy} !== '0) begin
            $display("FAIL reset_outputs got gnt=%b cnt=%0d flag=%b busy=%b want 0",
                     push_gnt, count, q_flag, busy);
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL reset_release got cnt=%0d busy=%b want 0/0", count, busy);
            errors++;
        end
    endtask

    task automatic test_push();
        push_data[0 +: DW] = 6'h15;
        push_req[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (push_gnt !== 4'b0001 || q_flag !== 2'b01 || q_data_in !== 6'h15) begin
            $display("FAIL push_issue got gnt=%b flag=%b din=%h want 0001/01/15",
                     push_gnt, q_flag, q_data_in);
            errors++;
        end
        push_req[0] = 1'b0;
        ref_q.push_back(6'h15);
        @(negedge clk);
        checks++;
        if (q_flag !== 2'b00 || q_data_in !== '0 || count !== 3'd1 || push_gnt !== '0) begin
            $display("FAIL push_after got flag=%b din=%h cnt=%0d want 00/00/1",
                     q_flag, q_data_in, count);
            errors++;
        end
        wait_idle();
    endtask

    task automatic test_full();
        logic seen;
        apply_reset();
        for (int i = 1; i <= 4; i++) do_push(i - 1, 6'(i));
        checks++;
        if (count !== 3'd4) begin
            $display("FAIL full_count got=%0d want 4", count);
            errors++;
        end
        push_data[1*DW +: DW] = 6'h05;
        push_req[1] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (push_gnt !== '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            $display("FAIL full_backpressure got grant want none");
            errors++;
        end
        do_pop(1);
        wait_push_gnt(1);
        push_req[1] = 1'b0;
        ref_q.push_back(6'h05);
        wait_idle();
        checks++;
        if (count !== 3'd4) begin
            $display("FAIL full_refill got=%0d want 4", count);
            errors++;
        end
        do_pop(3);
    endtask

    task automatic test_err_pop();
        apply_reset();
        do_push(2, 6'h21);
        do_pop(2);
        checks++;
        if (count !== 3'd1) begin
            $display("FAIL errpop_count got=%0d want 1", count);
            errors++;
        end
    endtask

    task automatic test_zero_drop();
        push_data[3*DW +: DW] = 6'h00;
        push_req[3] = 1'b1;
        wait_push_gnt(3);
        push_req[3] = 1'b0;
        checks++;
        if (zero_drop !== 1'b1 || q_flag !== 2'b00) begin
            $display("FAIL zero_drop got zd=%b flag=%b want 1/00", zero_drop, q_flag);
            errors++;
        end
        wait_idle();
        checks++;
        if (count !== 3'd1 || zero_drop !== 1'b0) begin
            $display("FAIL zero_after got cnt=%0d zd=%b want 1/0", count, zero_drop);
            errors++;
        end
    endtask

    task automatic test_arb();
        int exp;
        int n;
        apply_reset();
        push_data = '0;
        push_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
`ifdef QUEUE_SCHED_RR_EN
            exp = k % NP;
`else
            exp = 0;
`endif
            n = 0;
            while (push_gnt == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (push_gnt !== (4'b0001 << exp)) begin
                $display("FAIL arb_order k=%0d got=%b want=%b",
                         k, push_gnt, 4'b0001 << exp);
                errors++;
            end
            @(negedge clk);
        end
        push_req = '0;
        wait_idle();
        checks++;
        if (count !== 3'd0) begin
            $display("FAIL arb_count got=%0d want 0", count);
            errors++;
        end
    endtask

    task automatic test_contention();
        int n;
        apply_reset();
        do_push(0, 6'h0A);
        do_push(1, 6'h0B);
        sb.push_back({1'b0, ref_q[0]});
        ref_q.delete(0);
        pop_sel = 2'd0;
        pop_req = 1'b1;
        push_data[2*DW +: DW] = 6'h0C;
        push_req[2] = 1'b1;
        n = 0;
        while (!pop_gnt && push_gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pop_gnt !== 1'b1 || push_gnt !== '0) begin
            $display("FAIL contention_first got pop=%b push=%b want 1/0000",
                     pop_gnt, push_gnt);
            errors++;
        end
        pop_req = 1'b0;
        wait_push_gnt(2);
        push_req[2] = 1'b0;
        ref_q.push_back(6'h0C);
        wait_idle();
        checks++;
        if (count !== 3'd2) begin
            $display("FAIL contention_count got=%0d want 2", count);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        push_data[3*DW +: DW] = 6'h33;
        push_req[3] = 1'b1;
        wait_push_gnt(3);
        push_req[3] = 1'b0;
        #1 rst_n = 1'b0;
        ref_q.delete();
        sb.delete();
        #1;
        checks++;
        if ({push_gnt, pop_gnt, pop_valid, pop_err, pop_data, q_flag, q_sel,
             q_data_in, count, zero_drop, busy} !== '0) begin
            $display("FAIL reset_mid got gnt=%b flag=%b cnt=%0d busy=%b want 0",
                     push_gnt, q_flag, count, busy);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL reset_mid_after got cnt=%0d busy=%b want 0/0", count, busy);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_full();
        test_err_pop();
        test_zero_drop();
        test_arb();
        test_contention();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            $display("FAIL sb_drain got=%0d want 0", sb.size());
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
